// File: rtl/mac_pkg.sv
// Shared widths, beat tag and saturation-bound helpers for the streaming
// dot-product engine and its lane tree.
package mac_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Product width (PW) and lane-sum width (SW).
  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

  function automatic int sum_width(input int w, input int lanes);
    return 2 * w + clog2(lanes);
  endfunction

  // Bit patterns of the accumulator bounds, to be sized down to ACCW (< 64).
  function automatic logic [63:0] sat_max(input int accw, input logic sgn);
    return sgn ? ((64'd1 << (accw - 1)) - 64'd1) : ((64'd1 << accw) - 64'd1);
  endfunction

  function automatic logic [63:0] sat_min(input int accw, input logic sgn);
    return sgn ? (64'd1 << (accw - 1)) : 64'd0;
  endfunction

  typedef struct packed {
    logic first;
    logic last;
    logic signed_mode;
    logic sat_en;
  } beat_tag_t;

endpackage

// File: rtl/mac_lane_tree.sv
// Combinational LANES-wide multiply followed by a binary adder tree.
// Operands are sign- or zero-extended according to signed_mode.
module mac_lane_tree
  import mac_pkg::*;
#(
  parameter int W     = 8,
  parameter int LANES = 4
) (
  input  logic                             signed_mode,
  input  logic [LANES*W-1:0]               a,
  input  logic [LANES*W-1:0]               x,
  output logic [sum_width(W, LANES)-1:0]   sum
);

  localparam int PW = prod_width(W);
  localparam int SW = sum_width(W, LANES);

  // Heap-ordered tree: leaves at [LANES .. 2*LANES-1], root at index 1.
  logic [SW-1:0] node [1:2*LANES-1];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [PW-1:0] ae;
    logic [PW-1:0] xe;
    logic [PW-1:0] p;

    // Operands pre-extended to PW so the low PW product bits are exact
    // for both signed and unsigned interpretation.
    assign ae = {{W{signed_mode & a[i*W+W-1]}}, a[i*W +: W]};
    assign xe = {{W{signed_mode & x[i*W+W-1]}}, x[i*W +: W]};
    assign p  = ae * xe;

    if (SW > PW) begin : g_ext
      assign node[LANES+i] = {{(SW-PW){signed_mode & p[PW-1]}}, p};
    end else begin : g_noext
      assign node[LANES+i] = p;
    end
  end

  for (genvar k = 1; k < LANES; k++) begin : g_tree
    assign node[k] = node[2*k] + node[2*k+1];
  end

  assign sum = node[1];

endmodule

// File: rtl/mac_dot_stream.sv
// Streaming multi-lane dot-product engine: stage 1 registers the lane sum
// with first/last tags, stage 2 accumulates with optional saturation.
module mac_dot_stream
  import mac_pkg::*;
#(
  parameter int W     = 8,
  parameter int LANES = 4,
  parameter int ACCW  = 24,
  parameter int NMAX  = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic                      flush,
  input  logic [clog2(NMAX+1)-1:0]  len,
  input  logic                      signed_mode,
  input  logic                      sat_en,
  input  logic [LANES*W-1:0]        a,
  input  logic [LANES*W-1:0]        x,
  output logic [ACCW-1:0]           y,
  output logic                      y_valid,
  output logic                      ovf
);

  localparam int SW = sum_width(W, LANES);
  localparam int CW = clog2(NMAX + 1);

  localparam logic [ACCW-1:0] S_MAX = ACCW'(sat_max(ACCW, 1'b1));
  localparam logic [ACCW-1:0] S_MIN = ACCW'(sat_min(ACCW, 1'b1));
  localparam logic [ACCW-1:0] U_MAX = ACCW'(sat_max(ACCW, 1'b0));

  // Handshake: a beat transfers on every rising edge with in_valid=1 and
  // flush=0; there is no ready, and y_valid is a single-cycle pulse with
  // no backpressure.

  logic [CW-1:0]   cnt;
  logic [CW-1:0]   len_q;
  logic            mode_q;
  logic            sat_q;
  logic            s1_valid;
  logic [SW-1:0]   s1_sum;
  beat_tag_t       s1_tag;
  logic [ACCW-1:0] acc;
  logic            sticky;

  logic            first;
  logic            last;
  logic [CW-1:0]   cur_len;
  logic [CW-1:0]   eff_len;
  logic            cur_mode;
  logic            cur_sat;
  logic [SW-1:0]   lane_sum;

  // Configuration comes live on the first beat, latched thereafter.
  always_comb begin
    first    = (cnt == '0);
    cur_len  = first ? len : len_q;
    cur_mode = first ? signed_mode : mode_q;
    cur_sat  = first ? sat_en : sat_q;
    eff_len  = (cur_len == '0) ? CW'(1) : cur_len;
    last     = (cnt == eff_len - CW'(1));
  end

  mac_lane_tree #(
    .W     (W),
    .LANES (LANES)
  ) u_tree (
    .signed_mode (cur_mode),
    .a           (a),
    .x           (x),
    .sum         (lane_sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      len_q    <= '0;
      mode_q   <= 1'b0;
      sat_q    <= 1'b0;
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_tag   <= '0;
    end else if (flush) begin
      cnt      <= '0;
      s1_valid <= 1'b0;
    end else if (in_valid) begin
      s1_valid <= 1'b1;
      s1_sum   <= lane_sum;
      s1_tag   <= '{first: first, last: last, signed_mode: cur_mode, sat_en: cur_sat};
      cnt      <= last ? '0 : cnt + CW'(1);
      if (first) begin
        len_q  <= len;
        mode_q <= signed_mode;
        sat_q  <= sat_en;
      end
    end else begin
      s1_valid <= 1'b0;
    end
  end

  logic [ACCW:0]   sum_ext;
  logic [ACCW:0]   base_ext;
  logic [ACCW:0]   total;
  logic            over;
  logic [ACCW-1:0] clamp;
  logic [ACCW-1:0] result;

  // One guard bit above ACCW exposes overflow for both modes.
  always_comb begin
    sum_ext  = {{(ACCW+1-SW){s1_tag.signed_mode & s1_sum[SW-1]}}, s1_sum};
    base_ext = s1_tag.first ? '0 : {s1_tag.signed_mode & acc[ACCW-1], acc};
    total    = base_ext + sum_ext;
    over     = s1_tag.signed_mode ? (total[ACCW] ^ total[ACCW-1]) : total[ACCW];
    clamp    = s1_tag.signed_mode ? (total[ACCW] ? S_MIN : S_MAX) : U_MAX;
    result   = (over && s1_tag.sat_en) ? clamp : total[ACCW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      sticky  <= 1'b0;
      y       <= '0;
      y_valid <= 1'b0;
      ovf     <= 1'b0;
    end else if (flush) begin
      acc     <= '0;
      sticky  <= 1'b0;
      y_valid <= 1'b0;
    end else if (s1_valid) begin
      if (s1_tag.last) begin
        y       <= result;
        ovf     <= sticky | over;
        y_valid <= 1'b1;
        sticky  <= 1'b0;
      end else begin
        acc     <= result;
        sticky  <= sticky | over;
        y_valid <= 1'b0;
      end
    end else begin
      y_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_dot_stream.sv
// Self-checking bench for mac_dot_stream: a default instance (ACCW=24) and
// an ACCW=18 instance for saturation, both fed the same stream.
module tb_mac_dot_stream;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        flush;
  logic [10:0] len;
  logic        signed_mode;
  logic        sat_en;
  logic [31:0] a;
  logic [31:0] x;
  logic [23:0] y;
  logic        y_valid;
  logic        ovf;
  logic [17:0] y18;
  logic        y18_valid;
  logic        ovf18;

  mac_dot_stream u_dut (
    .clk (clk), .rst (rst), .in_valid (in_valid), .flush (flush), .len (len),
    .signed_mode (signed_mode), .sat_en (sat_en), .a (a), .x (x),
    .y (y), .y_valid (y_valid), .ovf (ovf)
  );

  mac_dot_stream #(.ACCW(18)) u_sat (
    .clk (clk), .rst (rst), .in_valid (in_valid), .flush (flush), .len (len),
    .signed_mode (signed_mode), .sat_en (sat_en), .a (a), .x (x),
    .y (y18), .y_valid (y18_valid), .ovf (ovf18)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [23:0] exp_q[$];
  logic        exp_ovf_q[$];
  logic [17:0] exp18_q[$];
  logic        exp18_ovf_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_valid = 0;
  bit          sat_chk = 0;

  // Reference model state
  int     m_cnt = 0;
  int     m_len = 1;
  bit     m_sgn = 0;
  bit     m_sat = 0;
  longint acc24 = 0;
  longint acc18 = 0;
  bit     ovf24 = 0;
  bit     o18 = 0;

  function automatic longint lane_sum(input logic [31:0] av, input logic [31:0] xv, input bit sgn);
    longint s;
    logic [7:0] ab;
    logic [7:0] xb;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      ab = av[i*8 +: 8];
      xb = xv[i*8 +: 8];
      if (sgn) s += longint'($signed(ab)) * longint'($signed(xb));
      else     s += longint'(ab) * longint'(xb);
    end
    return s;
  endfunction

  task automatic model_step(inout longint acc, inout bit o, input longint s,
                            input bit first, input bit sgn, input bit sat, input int accw);
    longint m, lo, hi, r;
    m  = longint'(1) << accw;
    lo = sgn ? -(m / 2) : 0;
    hi = sgn ? (m / 2 - 1) : (m - 1);
    r  = (first ? 0 : acc) + s;
    if (r < lo || r > hi) begin
      o = 1;
      if (sat) r = (r < lo) ? lo : hi;
      else begin
        r = ((r % m) + m) % m;
        if (sgn && r > hi) r -= m;
      end
    end
    acc = r;
  endtask

  always @(negedge clk) begin
    if (!rst && y_valid === 1'b1) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL y_valid_unexpected: y=%0h", y);
      end else begin
        logic [23:0] ey;
        logic        eo;
        ey = exp_q.pop_front();
        eo = exp_ovf_q.pop_front();
        n_cmp++;
        if (y !== ey) begin
          n_err++;
          $display("FAIL y: got %0h expected %0h", y, ey);
        end
        n_cmp++;
        if (ovf !== eo) begin
          n_err++;
          $display("FAIL ovf: got %0b expected %0b", ovf, eo);
        end
      end
    end
    if (!rst && sat_chk && y18_valid === 1'b1) begin
      if (exp18_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL y18_valid_unexpected: y18=%0h", y18);
      end else begin
        logic [17:0] ey18;
        logic        eo18;
        ey18 = exp18_q.pop_front();
        eo18 = exp18_ovf_q.pop_front();
        n_cmp++;
        if (y18 !== ey18) begin
          n_err++;
          $display("FAIL y18: got %0d expected %0d", y18, ey18);
        end
        n_cmp++;
        if (ovf18 !== eo18) begin
          n_err++;
          $display("FAIL ovf18: got %0b expected %0b", ovf18, eo18);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic beat(input logic [31:0] av, input logic [31:0] xv,
                      input int l, input bit sm, input bit se);
    bit     first, last;
    longint s;
    @(negedge clk);
    a = av; x = xv; len = 11'(l); signed_mode = sm; sat_en = se;
    in_valid = 1'b1; flush = 1'b0;
    first = (m_cnt == 0);
    if (first) begin
      m_len = (l == 0) ? 1 : l;
      m_sgn = sm; m_sat = se;
      ovf24 = 0; o18 = 0;
    end
    s = lane_sum(av, xv, m_sgn);
    model_step(acc24, ovf24, s, first, m_sgn, m_sat, 24);
    model_step(acc18, o18, s, first, m_sgn, m_sat, 18);
    last  = (m_cnt == m_len - 1);
    m_cnt = last ? 0 : m_cnt + 1;
    if (last) begin
      exp_q.push_back(acc24[23:0]);
      exp_ovf_q.push_back(ovf24);
      if (sat_chk) begin
        exp18_q.push_back(acc18[17:0]);
        exp18_ovf_q.push_back(o18);
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic do_flush(input bit with_beat);
    @(negedge clk);
    flush = 1'b1; in_valid = with_beat;
    a = $urandom; x = $urandom;
    m_cnt = 0; acc24 = 0; acc18 = 0; ovf24 = 0; o18 = 0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 10 && (exp_q.size() != 0 || exp18_q.size() != 0); i++) idle();
    idle();
    #1;
    n_cmp++;
    if (exp_q.size() != 0 || exp18_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: pending=%0d/%0d required 0", tag, exp_q.size(), exp18_q.size());
      exp_q.delete(); exp_ovf_q.delete(); exp18_q.delete(); exp18_ovf_q.delete();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; len = '0;
    signed_mode = 1'b0; sat_en = 1'b0; a = '0; x = '0;
    #1;
    n_cmp++; if (y !== 24'd0)  begin n_err++; $display("FAIL reset_y: got %0h required 0", y); end
    n_cmp++; if (y_valid !== 1'b0) begin n_err++; $display("FAIL reset_y_valid: got %0b required 0", y_valid); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %0b required 0", ovf); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_unsigned_basic();
    for (int i = 0; i < 3; i++) beat(32'h02020202, 32'h03030303, 3, 0, 0);
    idle();
    n_cmp++; if (y_valid !== 1'b0) begin n_err++; $display("FAIL latency_early: y_valid=%0b required 0", y_valid); end
    idle();
    n_cmp++; if (y_valid !== 1'b1) begin n_err++; $display("FAIL latency_pulse: y_valid=%0b required 1", y_valid); end
    n_cmp++; if (y !== 24'h000048) begin n_err++; $display("FAIL unsigned_y: got %0h required 48", y); end
    wait_drain("unsigned");
  endtask

  task automatic test_signed();
    for (int i = 0; i < 2; i++) beat(32'hFFFFFFFF, 32'h05050505, 2, 1, 0);
    wait_drain("signed");
    n_cmp++; if (y !== 24'hFFFFD8) begin n_err++; $display("FAIL signed_y: got %0h required FFFFD8", y); end
    for (int i = 0; i < 2; i++) beat(32'hFFFFFFFF, 32'h05050505, 2, 0, 0);
    wait_drain("unsigned_ff");
    n_cmp++; if (y !== 24'd10200) begin n_err++; $display("FAIL unsigned_ff_y: got %0d required 10200", y); end
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = n_valid;
    beat(32'h01010101, 32'h01010101, 2, 0, 0);
    idle();
    idle();
    n_cmp++; if (u_dut.acc !== acc24[23:0]) begin n_err++; $display("FAIL gap_acc: got %0d required %0d", u_dut.acc, acc24[23:0]); end
    idle();
    n_cmp++; if (u_dut.acc !== acc24[23:0]) begin n_err++; $display("FAIL gap_acc_hold: got %0d required %0d", u_dut.acc, acc24[23:0]); end
    beat(32'h01010101, 32'h01010101, 2, 0, 0);
    beat(32'h01010101, 32'h01010101, 2, 0, 0);
    beat(32'h01010101, 32'h01010101, 2, 0, 0);
    wait_drain("b2b");
    n_cmp++; if (n_valid - v0 != 2) begin n_err++; $display("FAIL b2b_pulses: got %0d required 2", n_valid - v0); end
    n_cmp++; if (y !== 24'd8) begin n_err++; $display("FAIL b2b_y: got %0d required 8", y); end
  endtask

  task automatic test_saturation();
    sat_chk = 1;
    for (int i = 0; i < 2; i++) beat(32'hFFFFFFFF, 32'hFFFFFFFF, 2, 0, 1);
    wait_drain("sat");
    n_cmp++; if (y18 !== 18'd262143) begin n_err++; $display("FAIL sat_y: got %0d required 262143", y18); end
    n_cmp++; if (ovf18 !== 1'b1) begin n_err++; $display("FAIL sat_ovf: got %0b required 1", ovf18); end
    n_cmp++; if (y !== 24'd520200) begin n_err++; $display("FAIL wide_y: got %0d required 520200", y); end
    for (int i = 0; i < 2; i++) beat(32'hFFFFFFFF, 32'hFFFFFFFF, 2, 0, 0);
    wait_drain("wrap");
    n_cmp++; if (y18 !== 18'd258056) begin n_err++; $display("FAIL wrap_y: got %0d required 258056", y18); end
    n_cmp++; if (ovf18 !== 1'b1) begin n_err++; $display("FAIL wrap_ovf: got %0b required 1", ovf18); end
    for (int i = 0; i < 2; i++) beat(32'h01010101, 32'h01010101, 2, 0, 1);
    wait_drain("clean");
    n_cmp++; if (ovf18 !== 1'b0) begin n_err++; $display("FAIL clean_ovf: got %0b required 0", ovf18); end
    sat_chk = 0;
  endtask

  task automatic test_flush();
    int v0;
    logic [23:0] y_old;
    y_old = y;
    v0 = n_valid;
    beat(32'h05050505, 32'h07070707, 4, 0, 0);
    beat(32'h05050505, 32'h07070707, 4, 0, 0);
    do_flush(1);
    repeat (3) idle();
    beat(32'h05050505, 32'h07070707, 4, 0, 0);
    beat(32'h05050505, 32'h07070707, 4, 0, 0);
    idle();
    do_flush(0);
    repeat (3) idle();
    n_cmp++; if (n_valid != v0) begin n_err++; $display("FAIL flush_no_pulse: got %0d pulses required 0", n_valid - v0); end
    n_cmp++; if (y !== y_old) begin n_err++; $display("FAIL flush_y_hold: got %0h required %0h", y, y_old); end
    for (int i = 0; i < 4; i++) beat(32'h01020304, 32'h01010101, 4, 0, 0);
    wait_drain("after_flush");
    n_cmp++; if (y !== 24'd40) begin n_err++; $display("FAIL after_flush_y: got %0d required 40", y); end
  endtask

  task automatic test_async_reset();
    beat(32'h03030303, 32'h03030303, 3, 0, 0);
    beat(32'h03030303, 32'h03030303, 3, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (y !== 24'd0) begin n_err++; $display("FAIL async_rst_y: got %0h required 0", y); end
    n_cmp++; if (y_valid !== 1'b0) begin n_err++; $display("FAIL async_rst_valid: got %0b required 0", y_valid); end
    m_cnt = 0; acc24 = 0; acc18 = 0; ovf24 = 0; o18 = 0;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) beat(32'h01010101, 32'h01010101, 2, 0, 0);
    wait_drain("post_rst");
    n_cmp++; if (y !== 24'd8) begin n_err++; $display("FAIL post_rst_y: got %0d required 8", y); end
  endtask

  task automatic test_len_zero_one();
    int v0;
    v0 = n_valid;
    for (int i = 0; i < 4; i++) beat($urandom, $urandom, 0, 1'($urandom_range(0, 1)), 0);
    for (int i = 0; i < 4; i++) beat($urandom, $urandom, 1, 1'($urandom_range(0, 1)), 0);
    wait_drain("len01");
    n_cmp++; if (n_valid - v0 != 8) begin n_err++; $display("FAIL len01_pulses: got %0d required 8", n_valid - v0); end
    v0 = n_valid;
    beat(32'h01010101, 32'h02020202, 3, 0, 0);
    beat(32'h01010101, 32'h02020202, 1, 0, 0);
    beat(32'h01010101, 32'h02020202, 1, 0, 0);
    wait_drain("len_change");
    n_cmp++; if (y !== 24'd24) begin n_err++; $display("FAIL len_change_y: got %0d required 24", y); end
    beat(32'h01010101, 32'h02020202, 1, 0, 0);
    wait_drain("len_next");
    n_cmp++; if (y !== 24'd8) begin n_err++; $display("FAIL len_next_y: got %0d required 8", y); end
    n_cmp++; if (n_valid - v0 != 2) begin n_err++; $display("FAIL len_change_pulses: got %0d required 2", n_valid - v0); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_unsigned_basic();
    test_signed();
    test_back_to_back();
    test_saturation();
    test_flush();
    test_async_reset();
    test_len_zero_one();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mac_dot_stream.md
Name: mac_dot_stream

Overview:
Streaming multi-lane dot-product engine for the MAC test-generator family. Each accepted beat carries LANES operand pairs. The block multiplies the pairs, sums them through an adder tree and accumulates over a runtime-programmable number of beats. It emits one result per vector with a valid pulse, signed/unsigned mode, optional saturation and a sticky overflow flag. It generalises the fixed-N, single-lane, wrap-only matrix MAC: adds lanes, handshake, runtime length, flush and saturation.

Parameters:
W, 8, operand bit-width
LANES, 4, operand pairs per beat (power of 2, >=1)
ACCW, 24, accumulator/result width; must satisfy ACCW >= 2W+clog2(LANES)
NMAX, 1024, maximum beats per vector

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  beat present; sampled every rising edge
flush  in  1  synchronous abort of the vector in progress
len  in  clog2(NMAX+1)  beats per vector; 0 treated as 1
signed_mode  in  1  1 = two's-complement operands
sat_en  in  1  1 = clamp on overflow, 0 = wrap
a  in  LANES*W  lane i at bits [i*W +: W]
x  in  LANES*W  lane i at bits [i*W +: W]
y  out  ACCW  dot-product result
y_valid  out  1  one-cycle pulse, y valid
ovf  out  1  overflow occurred in the vector reported with y

Behaviour:
- Reset (async, any time, including mid-vector) clears the following to 0: y, y_valid, ovf, acc, beat counter, stage-1 valid and sticky overflow. The first vector after reset starts fresh.
- Configuration latch: len, signed_mode and sat_en are captured on the first accepted beat of a vector (counter==0). Changes mid-vector are ignored until the next vector.
- Stage 1 (on the edge where in_valid=1): per-lane product of width 2W, sign- or zero-extended per the latched mode. Products are summed to width 2W+clog2(LANES) and registered with first/last tags. The counter increments and wraps to 0 on the beat where counter == len_latched-1.
- Stage 2 (edge after stage 1 holds a valid beat):
  - Base is 0 if first=1, otherwise acc.
  - Compute base + sum, sign/zero-extended to ACCW+1.
  - Overflow test: the result falls outside the ACCW range for the latched mode. Signed range is -2^(ACCW-1)..2^(ACCW-1)-1. Unsigned range is 0..2^ACCW-1.
  - Overflow sets sticky_ovf. With sat_en=1 the result clamps to the nearest bound; with sat_en=0 it is truncated mod 2^ACCW.
  - If last=1: y <= result, ovf <= sticky (including this beat), y_valid <= 1, sticky cleared. Otherwise acc <= result, y_valid <= 0.
- Latency: last beat sampled at edge t; y, y_valid and ovf update at edge t+1. Throughput is 1 beat/cycle, and back-to-back vectors run with no bubble.
- in_valid=0: counter and acc hold; stage-1 valid clears; y holds; y_valid=0.
- flush=1 at an edge:
  - Counter, acc, sticky and stage-1 valid clear, so the beat in stage 1 is discarded and no y_valid is produced for the aborted vector.
  - flush overrides a simultaneous in_valid; that beat is dropped.
  - y and ovf hold their last reported values.
- len=1 (or 0): every beat is both first and last, so y_valid fires each beat.
- y_valid has no backpressure; the consumer must accept it.

Decomposition:
- Shared package mac_pkg holds:
  - clog2 function
  - width constants PW=2W and SW=2W+clog2(LANES)
  - saturation bound constants/functions
  - beat-tag struct {first, last, signed_mode, sat_en}
- One natural sub-module: mac_lane_tree, the combinational LANES-wide multiply plus adder tree, parameterised by W, LANES and signedness.

Test Plan:
- Unsigned basic (W=8, LANES=4, ACCW=24): len=3, all a=2, x=3, three consecutive beats. Expect y=72 (0x000048) and y_valid one cycle after the third beat, ovf=0.
- Signed: len=2, all a=0xFF (-1), x=5. Expect y=0xFFFFD8 (-40), ovf=0. The same stimulus with signed_mode=0 must give 2*4*255*5 = 10200.
- Stall and back-to-back: len=2, beats interleaved with in_valid=0 gaps, followed immediately by a second vector of a=1, x=1. Expect results 8 then 8, exactly one y_valid per vector, and unchanged acc during gaps.
- Saturation (ACCW=18, unsigned, a=x=255, len=2): with sat_en=1 expect y=262143 and ovf=1. With sat_en=0 expect y=258056 and ovf=1. The next clean vector must report ovf=0.
- Flush and reset: flush after beat 2 of a len=4 vector, including a flush coincident with in_valid. Expect no y_valid, y holds its old value, and the following vector computes from zero. Async rst mid-vector clears y to 0 immediately without waiting for a clock edge.
- len=0 and len=1: every beat produces y_valid with y equal to that beat's lane sum. A len change mid-vector takes effect only on the next vector.
